// File: rtl/param_timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// param_timer_ctrl_if
// Purpose : groups the configuration, control and status signals of
//           param_timer_ctrl so the timer and its user connect through one
//           port.
// Signals :
//   en          global enable (prescaler and channel counters hold when 0)
//   cfg_wr      one-cycle configuration write strobe
//   cfg_ch      channel addressed by cfg_wr
//   cfg_period  channel period in prescaler ticks (0 is stored as 1)
//   cfg_mode    0 = one-shot, 1 = periodic
//   start/stop  per-channel level requests, sampled every cycle
//   q           prescaler value
//   tick        registered prescaler wrap pulse
//   busy        per-channel RUN indication
//   expire      per-channel one-cycle expiry pulse
// Handshake: there is no ready/valid pair. cfg_wr, start and stop are
// always accepted at the rising edge where they are sampled high; the
// effect is visible in the cycle after that edge.
// -----------------------------------------------------------------------------
interface param_timer_ctrl_if #(
   parameter int MOD = 40000,
   parameter int CH  = 4,
   parameter int W   = 16
);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam int QW = (MOD > 1) ? $clog2(MOD) : 1;

   logic          en;
   logic          cfg_wr;
   logic [CW-1:0] cfg_ch;
   logic [W-1:0]  cfg_period;
   logic          cfg_mode;
   logic [CH-1:0] start;
   logic [CH-1:0] stop;
   logic [QW-1:0] q;
   logic          tick;
   logic [CH-1:0] busy;
   logic [CH-1:0] expire;

   modport master (
      output en, cfg_wr, cfg_ch, cfg_period, cfg_mode, start, stop,
      input  q, tick, busy, expire
   );

   modport slave (
      input  en, cfg_wr, cfg_ch, cfg_period, cfg_mode, start, stop,
      output q, tick, busy, expire
   );
endinterface

// File: rtl/param_timer_ctrl.sv
// -----------------------------------------------------------------------------
// param_timer_ctrl
// Purpose : free-running prescaler (modulus MOD) producing a tick, plus CH
//           independent down-counting channels that count ticks and pulse
//           expire when their period elapses (one-shot or periodic).
// Ports   :
//   clk   rising-edge clock
//   rst_  synchronous active-low reset
//   bus   param_timer_ctrl_if.slave (config, start/stop, q, tick, busy,
//         expire)
// Each channel is a two-state FSM (IDLE/RUN); busy is the decode of the
// per-channel state register and serves as its observable state.
// -----------------------------------------------------------------------------
module param_timer_ctrl #(
   parameter int MOD = 40000,
   parameter int CH  = 4,
   parameter int W   = 16
) (
   input  logic               clk,
   input  logic               rst_,
   param_timer_ctrl_if.slave  bus
);
   localparam int              QW    = (MOD > 1) ? $clog2(MOD) : 1;
   localparam logic [QW-1:0]   Q_MAX = QW'(MOD - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   logic [QW-1:0] q_q, q_d;
   logic          tick_q, tick_d;
   logic [CH-1:0] expire_q, expire_d;
   logic [CH-1:0] mode_q, mode_d;
   state_e        state_q  [CH];
   state_e        state_d  [CH];
   logic [W-1:0]  rem_q    [CH];
   logic [W-1:0]  rem_d    [CH];
   logic [W-1:0]  period_q [CH];
   logic [W-1:0]  period_d [CH];
   logic [CH-1:0] run_vec;

   // Prescaler: counts only while enabled; tick marks the wrap one cycle
   // late because it is registered.
   always_comb begin
      q_d    = q_q;
      tick_d = 1'b0;
      if (bus.en) begin
         tick_d = (q_q == Q_MAX);
         q_d    = (q_q == Q_MAX) ? '0 : q_q + QW'(1);
      end
   end

   // Channel next-state logic. A same-cycle configuration write is folded
   // in first, so loads and reloads always use the freshly written values.
   always_comb begin
      expire_d = '0;
      mode_d   = mode_q;
      for (int i = 0; i < CH; i++) begin
         state_d[i]  = state_q[i];
         rem_d[i]    = rem_q[i];
         period_d[i] = period_q[i];

         if (bus.cfg_wr && (32'(bus.cfg_ch) == i)) begin
            period_d[i] = (bus.cfg_period == '0) ? W'(1) : bus.cfg_period;
            mode_d[i]   = bus.cfg_mode;
         end

         unique case (state_q[i])
            ST_IDLE: begin
               if (bus.start[i] && !bus.stop[i]) begin
                  state_d[i] = ST_RUN;
                  rem_d[i]   = period_d[i];
               end
            end
            ST_RUN: begin
               // stop beats start and a coinciding expiry; a restart
               // swallows a same-cycle tick.
               if (bus.stop[i]) begin
                  state_d[i] = ST_IDLE;
               end else if (bus.start[i]) begin
                  rem_d[i] = period_d[i];
               end else if (tick_q && bus.en) begin
                  if (rem_q[i] > W'(1)) begin
                     rem_d[i] = rem_q[i] - W'(1);
                  end else begin
                     expire_d[i] = 1'b1;
                     if (mode_d[i]) begin
                        rem_d[i] = period_d[i];
                     end else begin
                        state_d[i] = ST_IDLE;
                     end
                  end
               end
            end
            default: state_d[i] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         q_q      <= '0;
         tick_q   <= 1'b0;
         expire_q <= '0;
         mode_q   <= '0;
         for (int i = 0; i < CH; i++) begin
            state_q[i]  <= ST_IDLE;
            rem_q[i]    <= '0;
            period_q[i] <= W'(1);
         end
      end else begin
         q_q      <= q_d;
         tick_q   <= tick_d;
         expire_q <= expire_d;
         mode_q   <= mode_d;
         for (int i = 0; i < CH; i++) begin
            state_q[i]  <= state_d[i];
            rem_q[i]    <= rem_d[i];
            period_q[i] <= period_d[i];
         end
      end
   end

   always_comb begin
      run_vec = '0;
      for (int i = 0; i < CH; i++) begin
         run_vec[i] = (state_q[i] == ST_RUN);
      end
   end

   assign bus.q      = q_q;
   assign bus.tick   = tick_q;
   assign bus.busy   = run_vec;
   assign bus.expire = expire_q;
endmodule

// File: tb/tb_param_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_param_timer_ctrl
// Purpose : self-checking bench for param_timer_ctrl (MOD=4, CH=4, W=8).
// A reference model advances on every rising edge and pushes the expected
// {q, tick, busy, expire} into exp_q; a monitor on the falling edge pops and
// compares. Directed latency/count checks complement the scoreboard.
// -----------------------------------------------------------------------------
module tb_param_timer_ctrl;
   localparam int MOD = 4;
   localparam int CH  = 4;
   localparam int W   = 8;
   localparam int CW  = $clog2(CH);
   localparam int QW  = $clog2(MOD);
   localparam int EW  = QW + 1 + 2 * CH;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rst_ = 1'b0;
   always #5 clk = ~clk;

   param_timer_ctrl_if #(.MOD(MOD), .CH(CH), .W(W)) bus ();

   param_timer_ctrl #(.MOD(MOD), .CH(CH), .W(W)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int chk_cnt  = 0;
   int pass_cnt = 0;
   bit cnt_en   = 1'b0;
   int x1_cnt   = 0;

   // ---------------- reference model ----------------
   int m_q    = 0;
   bit m_tick = 1'b0;
   bit m_run      [CH];
   int m_rem      [CH];
   int m_per      [CH];
   bit m_periodic [CH];
   bit m_exp      [CH];

   always @(posedge clk) begin : ref_model
      logic [EW-1:0] e;
      logic [CH-1:0] bv;
      logic [CH-1:0] xv;
      bit            cur_tick;
      if (!rst_) begin
         m_q    = 0;
         m_tick = 1'b0;
         for (int i = 0; i < CH; i++) begin
            m_run[i]      = 1'b0;
            m_rem[i]      = 0;
            m_per[i]      = 1;
            m_periodic[i] = 1'b0;
            m_exp[i]      = 1'b0;
         end
      end else begin
         cur_tick = m_tick;
         for (int i = 0; i < CH; i++) begin
            m_exp[i] = 1'b0;
            if (bus.cfg_wr && int'(bus.cfg_ch) == i) begin
               m_per[i]      = (bus.cfg_period == 0) ? 1 : int'(bus.cfg_period);
               m_periodic[i] = bus.cfg_mode;
            end
            if (bus.stop[i]) begin
               m_run[i] = 1'b0;
            end else if (bus.start[i]) begin
               m_run[i] = 1'b1;
               m_rem[i] = m_per[i];
            end else if (m_run[i] && cur_tick && bus.en) begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_exp[i] = 1'b1;
                  if (m_periodic[i]) m_rem[i] = m_per[i];
                  else               m_run[i] = 1'b0;
               end
            end
         end
         m_tick = bus.en && (m_q == MOD - 1);
         if (bus.en) m_q = (m_q + 1) % MOD;
      end
      for (int i = 0; i < CH; i++) begin
         bv[i] = m_run[i];
         xv[i] = m_exp[i];
      end
      e = {QW'(m_q), m_tick, bv, xv};
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      if (cnt_en && bus.expire[1]) x1_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bus.q, bus.tick, bus.busy, bus.expire};
         chk_cnt++;
         if (a === e) begin
            pass_cnt++;
         end else begin
            $display("FAIL outputs t=%0t actual q=%0d tick=%b busy=%b expire=%b required q=%0d tick=%b busy=%b expire=%b",
                     $time, a[EW-1 -: QW], a[2*CH], a[2*CH-1 -: CH], a[CH-1:0],
                     e[EW-1 -: QW], e[2*CH], e[2*CH-1 -: CH], e[CH-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      chk_cnt++;
      if (act == req) pass_cnt++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, req);
   endtask

   task automatic do_cfg(input int ch, input int per, input bit mode);
      bus.cfg_wr     = 1'b1;
      bus.cfg_ch     = CW'(ch);
      bus.cfg_period = W'(per);
      bus.cfg_mode   = mode;
      step(1);
      bus.cfg_wr     = 1'b0;
   endtask

   task automatic pulse(input logic [CH-1:0] st, input logic [CH-1:0] sp);
      bus.start = st;
      bus.stop  = sp;
      step(1);
      bus.start = '0;
      bus.stop  = '0;
   endtask

   // Wait (bounded) until the model shows q==0 in the current cycle.
   task automatic align_q0(input string name);
      int n = 0;
      while (m_q != 0 && n < 16) begin
         step(1);
         n++;
      end
      check_int(name, int'(m_q == 0), 1);
   endtask

   // Count cycles after a start until expire[ch] is seen (bounded).
   task automatic wait_expire(input int ch, output int n);
      n = 0;
      while (!bus.expire[ch] && n < 200) begin
         step(1);
         n++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int n;
      int k;
      bus.en = 1'b0;  bus.cfg_wr = 1'b0;  bus.cfg_ch = '0;
      bus.cfg_period = '0;  bus.cfg_mode = 1'b0;
      bus.start = '0;  bus.stop = '0;

      // Reset with requests applied: they must be ignored.
      step(1);
      bus.en = 1'b1;  bus.start = '1;  bus.cfg_wr = 1'b1;  bus.cfg_period = 8'd5;
      step(2);
      bus.start = '0;  bus.cfg_wr = 1'b0;
      rst_ = 1'b1;
      step(12);                                 // free-running prescaler

      // One-shot, period 3, aligned start: ticks in cycles 4, 8, 12 after
      // the start cycle, expiry visible 12 steps after the start edge.
      do_cfg(0, 3, 1'b0);
      align_q0("align_a");
      pulse(4'b0001, 4'b0000);
      check_int("busy0_after_start", int'(bus.busy[0]), 1);
      wait_expire(0, n);
      check_int("oneshot_latency", n, 12);
      check_int("busy0_falls_with_expire", int'(bus.busy[0]), 0);
      step(4);

      // Same start, but en low for 10 cycles right after it.
      align_q0("align_b");
      pulse(4'b0001, 4'b0000);
      bus.en = 1'b0;
      step(10);
      bus.en = 1'b1;
      wait_expire(0, k);
      check_int("en_gap_latency", k + 10, 22);
      step(4);

      // Periodic, period 2 -> an expiry every 8 cycles.
      do_cfg(1, 2, 1'b1);
      pulse(4'b0010, 4'b0000);
      step(16);
      x1_cnt = 0;
      cnt_en = 1'b1;
      step(32);
      cnt_en = 1'b0;
      check_int("periodic_pulse_count", x1_cnt, 4);
      pulse(4'b0000, 4'b0010);
      check_int("busy1_after_stop", int'(bus.busy[1]), 0);
      x1_cnt = 0;
      cnt_en = 1'b1;
      step(20);
      cnt_en = 1'b0;
      check_int("no_pulse_after_stop", x1_cnt, 0);

      // start+stop together on an idle channel.
      pulse(4'b0100, 4'b0100);
      check_int("ch2_idle_startstop", int'(bus.busy[2]), 0);

      // start+stop together on a running channel at its expiry tick.
      do_cfg(2, 1, 1'b0);
      pulse(4'b0100, 4'b0000);
      n = 0;
      while (!(m_run[2] && m_rem[2] == 1 && m_tick) && n < 16) begin
         step(1);
         n++;
      end
      check_int("ch2_reached_expiry_tick", int'(n < 16), 1);
      pulse(4'b0100, 4'b0100);
      check_int("ch2_stop_at_expiry_busy", int'(bus.busy[2]), 0);
      check_int("ch2_stop_at_expiry_expire", int'(bus.expire[2]), 0);
      step(4);

      // Reset while all channels run; period must come back as 1.
      do_cfg(3, 7, 1'b1);
      pulse(4'b1111, 4'b0000);
      step(3);
      rst_ = 1'b0;
      step(1);
      rst_ = 1'b1;
      check_int("busy_after_reset", int'(bus.busy), 0);
      check_int("q_after_reset", int'(bus.q), 0);
      step(1);
      align_q0("align_c");
      pulse(4'b0001, 4'b0000);
      wait_expire(0, n);
      check_int("default_period_latency", n, 4);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         bus.en         = ($urandom_range(0, 9) != 0);
         bus.cfg_wr     = ($urandom_range(0, 5) == 0);
         bus.cfg_ch     = CW'($urandom_range(0, CH - 1));
         bus.cfg_period = W'($urandom_range(0, 6));
         bus.cfg_mode   = 1'($urandom_range(0, 1));
         for (int i = 0; i < CH; i++) begin
            bus.start[i] = ($urandom_range(0, 9) == 0);
            bus.stop[i]  = ($urandom_range(0, 15) == 0);
         end
         rst_ = ($urandom_range(0, 99) != 0);
         step(1);
      end
      rst_ = 1'b1;
      bus.cfg_wr = 1'b0;  bus.start = '0;  bus.stop = '0;  bus.en = 1'b1;
      step(4);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/param_timer_ctrl.md
PARAM_TIMER_CTRL -- requirements
Module: param_timer_ctrl

Interface
REQ-001 Parameter MOD, default 40000, prescaler modulus (MOD >= 2).
REQ-002 Parameter CH, default 4, number of timer channels (CH >= 2).
REQ-003 Parameter W, default 16, channel period width in bits.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 Port en  input  1  global enable; when low, prescaler and all channel counters hold.
REQ-007 Port cfg_wr  input  1  configuration write strobe, one cycle per write.
REQ-008 Port cfg_ch  input  $clog2(CH)  channel index for cfg_wr; values >= CH are ignored.
REQ-009 Port cfg_period  input  W  period in ticks; a value of 0 is stored as 1.
REQ-010 Port cfg_mode  input  1  0 = one-shot, 1 = periodic.
REQ-011 Port start  input  CH  per-channel start/restart request, level-sampled each cycle.
REQ-012 Port stop  input  CH  per-channel stop request, level-sampled each cycle.
REQ-013 Port q  output  $clog2(MOD)  current prescaler value, range 0..MOD-1.
REQ-014 Port tick  output  1  registered prescaler wrap pulse.
REQ-015 Port busy  output  CH  registered; 1 while the channel is in RUN.
REQ-016 Port expire  output  CH  registered one-cycle expiry pulse per channel.

Function
REQ-017 Prescaler SHALL increment when en=1 and wrap from MOD-1 to 0; q SHALL equal the prescaler register.
REQ-018 tick SHALL be 1 in the cycle after a cycle with en=1 and q==MOD-1, and 0 otherwise.
REQ-019 Each channel SHALL hold period[W-1:0], mode, remaining count rem[W-1:0] and a 2-state FSM: IDLE, RUN.
REQ-020 cfg_wr SHALL update period/mode of channel cfg_ch on the next edge; in RUN, rem SHALL be unaffected and the new period SHALL apply from the next reload.
REQ-021 IDLE -> RUN: start[i]=1 and stop[i]=0; rem SHALL load period[i] (after any same-cycle cfg_wr to i) and busy[i] SHALL be 1 on the next cycle.
REQ-022 In RUN, start[i]=1 and stop[i]=0 SHALL reload rem=period[i]; a tick in the same cycle SHALL NOT be counted.
REQ-023 In RUN, stop[i]=1 SHALL go to IDLE on the next edge, with priority over start[i] and over a same-cycle expiry; expire[i] stays 0.
REQ-024 In RUN with tick=1, en=1 and rem>1: rem SHALL decrement by 1.
REQ-025 In RUN with tick=1, en=1 and rem==1: expire[i] SHALL be 1 for the next cycle; periodic -> rem reloads period[i], stays RUN; one-shot -> IDLE, busy[i] falls on the same edge expire[i] rises.
REQ-026 en=0 SHALL freeze q, rem and FSM state; tick SHALL be 0; start, stop and cfg_wr SHALL still take effect.
REQ-027 Channels SHALL be independent; several expire bits may pulse in the same cycle.
REQ-028 Latency: one-shot period P, started in cycle t with continuous en=1, SHALL expire exactly one cycle after the P-th tick following t.

Reset
REQ-029 With rst_=0 at a rising edge, these SHALL clear on that edge, regardless of any in-flight operation: q=0, tick=0, busy=0, expire=0, all FSMs to IDLE, rem=0, period=1, mode=0.
REQ-030 While rst_=0, start, stop, cfg_wr and en SHALL be ignored.

Verification (MOD=4, CH=4, W=8)
REQ-031 Reset released, en=1 held -> q sequence 0,1,2,3,0,...; tick=1 in every cycle after q==3 (period 4 cycles); all busy/expire 0.
REQ-032 cfg ch0 period=3 one-shot, then start[0] -> busy[0]=1 next cycle; expire[0] one 1-cycle pulse one cycle after the 3rd tick; busy[0]=0 on that same edge.
REQ-033 cfg ch1 period=2 periodic, start[1] -> expire[1] pulses every 8 cycles until stop[1]; after stop, busy[1]=0 and no further pulses.
REQ-034 start[2] and stop[2] asserted together on an IDLE channel -> stays IDLE; on a RUN channel whose expiry tick coincides -> IDLE, expire[2]=0.
REQ-035 en=0 for 10 cycles mid-run on ch0 (period 3) -> q and rem frozen, tick=0; expiry delayed by exactly 10 cycles.
REQ-036 rst_=0 for 1 cycle while ch0..ch3 run -> all outputs 0 next cycle; period reads back as 1 (start with no cfg -> expire one cycle after the 1st tick).
